// File: rtl/dma_responder.sv
// rtl/dma_responder.sv - DMA request responder with latency-modelled local word store.
// Optional range checking: define DMA_RESPONDER_RANGE_CHECK_EN.
module dma_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dma_addr,
  input  logic [15:0] dma_wdata,
  input  logic        dma_we,
  input  logic        dma_ce,
  output logic [15:0] dma_rdata,
  output logic        dma_done,
  output logic        dma_busy,
  output logic        dma_err,
  output logic [15:0] xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_addr;
  logic          r_we;
  logic [15:0]   r_wdata;
  logic [CW-1:0] r_lat_cnt;
  logic [15:0]   r_rdata;
  logic [15:0]   r_xfer;
  logic [15:0]   r_mem [DEPTH];

  logic [31:0]   w_offset;
  logic [AW-1:0] w_index;
  logic          w_in_range;
  logic          w_finish;
  logic          w_unused;

  assign w_offset = r_addr - BASE_ADDR;
  assign w_index  = w_offset[AW:1];
  assign w_unused = ^{w_offset[31:AW+1], w_offset[0]};
  assign w_finish = (r_state == S_BUSY) && (r_lat_cnt == '0);

`ifdef DMA_RESPONDER_RANGE_CHECK_EN
  logic r_err;

  assign w_in_range = (r_addr >= BASE_ADDR) && (w_offset[31:1] < 31'(DEPTH));
  assign dma_err    = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_finish && !w_in_range) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_in_range = 1'b1;
  assign dma_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (dma_ce) w_next = S_BUSY;
      S_BUSY: if (r_lat_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_HOLD;
      S_HOLD: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dma_busy = 1'b0;
    dma_done = 1'b0;
    case (r_state)
      S_BUSY: dma_busy = 1'b1;
      S_DONE: dma_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_lat_cnt <= '0;
      r_rdata   <= '0;
      r_xfer    <= '0;
    end else begin
      if (r_state == S_IDLE && dma_ce) begin
        r_addr    <= dma_addr;
        r_we      <= dma_we;
        r_wdata   <= dma_wdata;
        r_lat_cnt <= LAT_LOAD;
      end else if (r_state == S_BUSY && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
      if (w_finish && !r_we) begin
        r_rdata <= w_in_range ? r_mem[w_index] : 16'hDEAD;
      end
      if (r_state == S_DONE) begin
        r_xfer <= r_xfer + 16'd1;
      end
    end
  end

  // Store is not reset; an async reset drops the state to IDLE so w_finish cannot fire.
  always_ff @(posedge clk) begin
    if (w_finish && r_we && w_in_range) begin
      r_mem[w_index] <= r_wdata;
    end
  end

  assign dma_rdata  = r_rdata;
  assign xfer_count = r_xfer;

endmodule

// File: doc/dma_responder.md
DMA_RESPONDER -- requirements
Module: dma_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, local backing-store size in 16-bit words; power of two.
REQ-002 SHALL have parameter LATENCY, default 4, number of BUSY cycles per request; at least 1.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address that maps to word 0.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port dma_addr  input  32  byte address of the request.
REQ-007 SHALL have port dma_wdata  input  16  write data.
REQ-008 SHALL have port dma_we  input  1  1 = write, 0 = read; qualified by dma_ce.
REQ-009 SHALL have port dma_ce  input  1  request present; level, held by the initiator.
REQ-010 SHALL have port dma_rdata  output  16  read data; valid while dma_done=1.
REQ-011 SHALL have port dma_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port dma_busy  output  1  request in progress.
REQ-013 SHALL have port dma_err  output  1  sticky range-error flag (see Configuration).
REQ-014 SHALL have port xfer_count  output  16  count of completed requests.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE, HOLD.
REQ-016 IDLE: SHALL capture dma_addr, dma_we and dma_wdata on any edge where dma_ce=1, then go to BUSY; otherwise SHALL stay in IDLE.
REQ-017 BUSY: dma_busy=1; SHALL stay exactly LATENCY cycles (down-counter), then go to DONE; dma_ce/dma_addr changes are ignored.
REQ-018 Word index SHALL be (captured_addr - BASE_ADDR) >> 1, 32-bit unsigned subtraction; bit 0 is ignored.
REQ-019 On the BUSY->DONE edge, a read SHALL load dma_rdata from mem[index]; a write SHALL store the captured wdata to mem[index] and leave dma_rdata unchanged.
REQ-020 DONE: dma_done=1 and dma_busy=0 for exactly one cycle; xfer_count SHALL increment by 1 on the DONE->HOLD edge and wrap 16'hFFFF->0.
REQ-021 HOLD: SHALL last exactly one cycle and ignore dma_ce, so the initiator's registered address can advance; then go to IDLE.
REQ-022 Back-to-back requests with dma_ce held high: capture-to-capture period SHALL be LATENCY+3 cycles.
REQ-023 dma_rdata SHALL hold its value outside DONE until the next read completes.
REQ-024 dma_busy and dma_done SHALL never be high together.
REQ-025 A read of a word written by an earlier completed request SHALL return the written data (no bypass needed; accesses are serialized).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, dma_busy=0, dma_done=0, dma_rdata=16'h0, dma_err=0, xfer_count=0, and clear the latency counter.
REQ-027 Reset mid-request SHALL abort the request with no memory write and no done pulse; backing-store contents are not reset.
REQ-028 After rst_n deasserts, the first capture SHALL occur on the first edge with dma_ce=1.

Configuration
REQ-029 Macro DMA_RESPONDER_RANGE_CHECK_EN defined: index >= DEPTH or addr < BASE_ADDR SHALL suppress the memory access, return dma_rdata=16'hDEAD for reads, and set dma_err=1 until reset; timing is unchanged.
REQ-030 Macro undefined: index SHALL wrap modulo DEPTH, and dma_err SHALL be tied 0; the port is present in both builds.

Verification
REQ-031 Write 0x1234 to addr 0x10, then read addr 0x10 -> dma_done pulses one cycle with dma_rdata=0x1234; xfer_count=2.
REQ-032 LATENCY=4, single read -> dma_busy high for exactly 4 cycles starting one cycle after capture; dma_done the following cycle.
REQ-033 dma_ce held high with address stepping by 2 on each dma_done (scheduler style), 8 reads -> 8 done pulses, each address read once, period 7 cycles.
REQ-034 rst_n pulsed low during BUSY of a write 0xBEEF to addr 0x20 -> outputs reset immediately, no dma_done, mem[0x10] unchanged.
REQ-035 With RANGE_CHECK_EN, DEPTH=1024, read addr 0x800 -> dma_rdata=0xDEAD, dma_err=1 stays high; without the macro -> returns mem[0], dma_err=0.
REQ-036 1-cycle dma_ce pulse in IDLE -> request completes normally; a dma_ce pulse during HOLD is ignored.
